// File: rtl/eth_arb_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: FSM encoding and index-width helper.
package eth_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first requester searching upward (wrapping) from last_grant+1.
module rr_priority_select import eth_arb_pkg::*; #(
  parameter int unsigned PORTS = 4,
  localparam int unsigned IDX_W = clog2(PORTS)
) (
  input  logic [PORTS-1:0] request,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  int unsigned cand;

  // Walk from the farthest offset to the nearest so the closest requester overwrites.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned off = PORTS; off >= 1; off--) begin
      cand = (32'(last_grant) + off) % PORTS;
      if (request[IDX_W'(cand)]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter merging PORTS AXI-Stream sources onto one MAC TX stream
// through a single output register stage.
module eth_tx_frame_arbiter import eth_arb_pkg::*; #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned IDX_W     = clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  input  logic [PORTS-1:0]            port_enable,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_index
);

  arb_state_e            state_q, state_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]      grant_index_q, grant_index_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;

  logic [PORTS-1:0]      req_c;
  logic                  rr_valid_c;
  logic [IDX_W-1:0]      rr_index_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic                  sel_valid_c, sel_last_c, sel_user_c;
  logic                  out_ready_c, accept_c;

  assign req_c = s_axis_tvalid & port_enable;

  rr_priority_select #(.PORTS(PORTS)) u_rr (
    .request    (req_c),
    .last_grant (last_grant_q),
    .valid      (rr_valid_c),
    .index      (rr_index_c)
  );

  // Granted-port beat mux.
  always_comb begin
    sel_data_c  = '0;
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_user_c  = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant_index_q == IDX_W'(p)) begin
        sel_data_c  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_valid_c = s_axis_tvalid[IDX_W'(p)];
        sel_last_c  = s_axis_tlast[IDX_W'(p)];
        sel_user_c  = s_axis_tuser[IDX_W'(p)];
      end
    end
  end

  // Next-state, ready generation and output-register load.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    last_grant_d  = last_grant_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    tvalid_d      = tvalid_q & ~m_axis_tready;
    s_axis_tready = '0;
    out_ready_c   = ~tvalid_q | m_axis_tready;
    accept_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_valid_c) begin
          state_d       = ST_XFER;
          grant_valid_d = 1'b1;
          grant_index_d = rr_index_c;
        end
      end
      ST_XFER: begin
        s_axis_tready[grant_index_q] = out_ready_c;
        accept_c = sel_valid_c & out_ready_c;
        if (accept_c) begin
          tdata_d  = sel_data_c;
          tlast_d  = sel_last_c;
          tuser_d  = sel_user_c;
          tvalid_d = 1'b1;
          // Release on the accepted end-of-frame beat; next pick happens in IDLE.
          if (sel_last_c) begin
            last_grant_d  = grant_index_q;
            grant_valid_d = 1'b0;
            state_d       = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      last_grant_q  <= IDX_W'(PORTS - 1);
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign grant_valid   = grant_valid_q;
  assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter against a frame-level round-robin reference model.
module tb_eth_tx_frame_arbiter;

  localparam int unsigned PORTS = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 2;

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] data;
    logic       last;
    logic       user;
  } tb_beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PORTS*DW-1:0]   s_axis_tdata;
  logic [PORTS-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [DW-1:0]         m_axis_tdata;
  logic                  m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [PORTS-1:0]      port_enable;
  logic                  grant_valid;
  logic [IW-1:0]         grant_index;

  eth_tx_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .port_enable   (port_enable),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who holds the grant and what sits in the output register.
  tb_beat_t src [PORTS][$];
  bit       acc_flag [PORTS];
  int       acc_cnt [PORTS];
  int       deliv_last_p [PORTS];
  int       gq [$];
  bit       mgv, mov;
  int       mport, mlast;
  tb_beat_t mbeat;
  int       deliv_beats, deliv_last;
  int       gap_pct, rdy_mode, cyc;
  logic [PORTS-1:0] next_enable;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [PORTS-1:0] req, input int last);
    for (int k = 1; k <= PORTS; k++)
      if (req[(last + k) % PORTS]) return (last + k) % PORTS;
    return -1;
  endfunction

  task automatic add_frame(input int p, input int len);
    tb_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.port = 3'(p);
      b.data = 8'($urandom);
      b.last = (i == len - 1);
      b.user = 1'($urandom);
      src[p].push_back(b);
    end
  endtask

  task automatic clear_stats();
    gq.delete();
    deliv_beats = 0;
    deliv_last  = 0;
    for (int p = 0; p < PORTS; p++) begin
      acc_cnt[p]      = 0;
      deliv_last_p[p] = 0;
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < PORTS; p++) begin
      src[p].delete();
      acc_flag[p] = 1'b0;
    end
    s_axis_tvalid = '0;
    mgv   = 1'b0;
    mov   = 1'b0;
    mport = 0;
    mlast = PORTS - 1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 0);
    check_eq("rst_m_tdata", 32'(m_axis_tdata), 0);
    check_eq("rst_m_tlast", 32'(m_axis_tlast), 0);
    check_eq("rst_m_tuser", 32'(m_axis_tuser), 0);
    check_eq("rst_grant_valid", 32'(grant_valid), 0);
    check_eq("rst_grant_index", 32'(grant_index), 0);
    check_eq("rst_s_tready", 32'(s_axis_tready), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare with the model, then advance the model.
  task automatic cycle();
    tb_beat_t         d;
    logic [PORTS-1:0] req, exp_rdy;
    bit               acc_v;
    int               acc_p;
    @(negedge clk);
    cyc++;
    port_enable = next_enable;
    for (int p = 0; p < PORTS; p++) begin
      if (acc_flag[p]) begin
        s_axis_tvalid[p] = 1'b0;
        acc_flag[p] = 1'b0;
      end
      if (!s_axis_tvalid[p] && src[p].size() > 0 && $urandom_range(99) >= gap_pct)
        s_axis_tvalid[p] = 1'b1;
      if (s_axis_tvalid[p]) begin
        d = src[p][0];
        s_axis_tdata[p*DW +: DW] = d.data;
        s_axis_tlast[p] = d.last;
        s_axis_tuser[p] = d.user;
      end else begin
        s_axis_tdata[p*DW +: DW] = 8'($urandom);
        s_axis_tlast[p] = 1'($urandom);
        s_axis_tuser[p] = 1'($urandom);
      end
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(1));
    endcase
    #1;
    exp_rdy = '0;
    if (mgv && (!mov || m_axis_tready)) exp_rdy[mport] = 1'b1;
    check_eq("grant_valid", 32'(grant_valid), 32'(mgv));
    if (mgv) check_eq("grant_index", 32'(grant_index), 32'(mport));
    check_eq("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    check_eq("m_tvalid", 32'(m_axis_tvalid), 32'(mov));
    if (mov)
      check_eq("m_beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
               32'({mbeat.data, mbeat.last, mbeat.user}));

    if (mov && m_axis_tready) begin
      deliv_beats++;
      if (mbeat.last) begin
        deliv_last++;
        deliv_last_p[mbeat.port]++;
      end
    end
    req   = s_axis_tvalid & port_enable;
    acc_v = 1'b0;
    acc_p = 0;
    for (int p = 0; p < PORTS; p++)
      if (s_axis_tvalid[p] && exp_rdy[p]) begin
        acc_v = 1'b1;
        acc_p = p;
      end
    mov = acc_v ? 1'b1 : (mov && !m_axis_tready);
    if (acc_v) begin
      mbeat = src[acc_p].pop_front();
      acc_flag[acc_p] = 1'b1;
      acc_cnt[acc_p]++;
    end
    if (!mgv && req != '0) begin
      mgv   = 1'b1;
      mport = rr_pick(req, mlast);
      gq.push_back(mport);
    end else if (mgv && acc_v && mbeat.last) begin
      mgv   = 1'b0;
      mlast = mport;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = mgv || mov || (s_axis_tvalid != '0);
    for (int p = 0; p < PORTS; p++) b |= (src[p].size() > 0) || acc_flag[p];
    return b;
  endfunction

  task automatic drain(input int budget);
    int n;
    bit timed_out;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    timed_out = busy();
    check_eq("drain_timeout", 32'(timed_out), 0);
  endtask

  initial begin
    int t_req, t_out, n, cnt;
    bit cleared;
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b1;
    port_enable = '1; next_enable = '1;
    gap_pct = 0; rdy_mode = 0; cyc = 0;
    model_clear();
    clear_stats();
    #1;
    check_reset_outputs();
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Single 64-byte frame on port 0.
    add_frame(0, 64);
    t_req = -1; t_out = -1; n = 0;
    while (busy() && n < 500) begin
      cycle();
      n++;
      if (t_req < 0 && s_axis_tvalid[0]) t_req = cyc;
      if (t_out < 0 && m_axis_tvalid) t_out = cyc;
    end
    check_eq("single_latency", 32'(t_out - t_req), 2);
    check_eq("single_beats", 32'(deliv_beats), 64);
    check_eq("single_tlasts", 32'(deliv_last), 1);
    check_eq("single_grants", 32'(gq.size()), 1);
    if (gq.size() > 0) check_eq("single_port", 32'(gq[0]), 0);

    // Contention: ports 0,1,2 ready at reset release.
    do_reset();
    clear_stats();
    for (int p = 0; p < 3; p++) add_frame(p, 10);
    drain(500);
    check_eq("cont_grants", 32'(gq.size()), 3);
    for (int i = 0; i < gq.size(); i++) check_eq("cont_order", 32'(gq[i]), 32'(i));

    // Fairness between ports 1 and 3.
    do_reset();
    clear_stats();
    for (int f = 0; f < 8; f++) begin
      add_frame(1, 4);
      add_frame(3, 4);
    end
    drain(1000);
    check_eq("fair_grants", 32'(gq.size()), 16);
    for (int i = 0; i < gq.size(); i++) check_eq("fair_order", 32'(gq[i]), (i % 2) ? 3 : 1);

    // Backpressure with alternating sink ready.
    do_reset();
    clear_stats();
    rdy_mode = 1;
    add_frame(0, 20);
    drain(500);
    check_eq("bp_beats", 32'(deliv_beats), 20);
    check_eq("bp_tlasts", 32'(deliv_last), 1);
    rdy_mode = 0;

    // Masking, and disabling the granted port mid-frame.
    do_reset();
    clear_stats();
    next_enable = 4'b1101;
    for (int p = 0; p < PORTS; p++) begin
      add_frame(p, 8);
      add_frame(p, 8);
    end
    cleared = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (!cleared && mgv && mport == 2 && acc_cnt[2] >= 3) begin
        next_enable = 4'b1001;
        cleared = 1'b1;
      end
    end
    cnt = 0;
    foreach (gq[i]) if (gq[i] == 1) cnt++;
    check_eq("mask_p1_grants", 32'(cnt), 0);
    cnt = 0;
    foreach (gq[i]) if (gq[i] == 2) cnt++;
    check_eq("mask_p2_grants", 32'(cnt), 1);
    check_eq("mask_p2_frame_done", 32'(deliv_last_p[2]), 1);
    check_eq("mask_p0_frames", 32'(deliv_last_p[0]), 2);
    next_enable = '1;

    // Randomized traffic with gaps, sink stalls and single-beat frames.
    do_reset();
    clear_stats();
    gap_pct = 30;
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) add_frame($urandom_range(PORTS - 1), $urandom_range(1, 12));
    add_frame(2, 1);
    drain(3000);
    gap_pct = 0;
    rdy_mode = 0;

    // Reset during beat 5 of a port 2 frame.
    do_reset();
    clear_stats();
    add_frame(2, 20);
    n = 0;
    while (acc_cnt[2] < 5 && n < 100) begin
      cycle();
      n++;
    end
    check_eq("mid_rst_reached", 32'(acc_cnt[2]), 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    add_frame(2, 6);
    add_frame(0, 6);
    drain(500);
    check_eq("post_rst_grants", 32'(gq.size()), 2);
    if (gq.size() > 0) check_eq("post_rst_first", 32'(gq[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
